// File: rtl/sram_pkg.sv
// Shared voltage levels and FSM state encoding for the SRAM bank and its cells.
package sram_pkg;

  localparam real VDD  = 1.5;
  localparam real VSS  = 0.0;
  localparam real VTH  = 0.8;
  localparam real VMIN = 1.2;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    ACCESS,
    SENSE,
    DONE
  } state_e;

endpackage

// File: rtl/sram_cell.sv
// One bit of storage.
// The cell is written when its wordline is high and its bitlines are driven
// differentially. A precharged pair (both lines high) leaves the stored bit alone.
module sram_cell
  import sram_pkg::*;
(
  input  logic clk_i,
  input  real  wl_i,
  input  real  bl_i,
  input  real  blb_i,
  output real  q_o
);

  logic bit_q;

  // Storage node: it has no reset, so the contents survive a bank reset.
  always_ff @(posedge clk_i) begin
    if (wl_i >= VTH) begin
      if ((bl_i >= VTH) && (blb_i < VTH)) begin
        bit_q <= 1'b1;
      end else if ((bl_i < VTH) && (blb_i >= VTH)) begin
        bit_q <= 1'b0;
      end
    end
  end

  // Present the stored bit as a node voltage for the bank's sense logic.
  always_comb begin
    q_o = bit_q ? VDD : VSS;
  end

endmodule

// File: rtl/sram_bank.sv
// SRAM bank sequencer.
// The state machine runs each access as: precharge, wordline pulse, optional
// sense, then a done cycle. Storage is a ROWS x COLS grid of sram_cell instances.
module sram_bank
  import sram_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int COLS       = 8,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] addr,
  input  logic [COLS-1:0]         wdata,
  input  real                     vdd,
  output logic                    ack,
  output logic                    err,
  output logic                    busy,
  output logic [COLS-1:0]         rdata,
  output real                     wl [ROWS]
);

  localparam int AW   = $clog2(ROWS);
  localparam int MAXC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] wdata_q, wdata_d;
  logic [COLS-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            accessing;
  logic [COLS-1:0] sensed;
  real             bl [COLS];
  real             blb [COLS];
  real             cellV [ROWS][COLS];

  // Next-state logic.
  // The request is latched and checked once, in IDLE. A failed check skips
  // straight to DONE, so no wordline is ever raised for a rejected access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          if ((int'(addr) >= ROWS) || (vdd < VMIN)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = PRECHARGE;
          end
        end
      end
      PRECHARGE: begin
        if (cnt_q == CW'(PRE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACCESS: begin
        if (cnt_q == CW'(WL_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = we_q ? DONE : SENSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SENSE: begin
        rdata_d = sensed;
        state_d = DONE;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers.
  // Reset returns the sequencer to IDLE but leaves the cell array untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Status outputs.
  // These are gated by rst so that an abort is visible immediately.
  always_comb begin
    accessing = (state_q == ACCESS) && !rst;
    ack       = (state_q == DONE) && !rst;
    err       = ack && err_q;
    busy      = (state_q != IDLE) && !rst;
    rdata     = rst ? '0 : rdata_q;
  end

  // Wordline drivers: only the latched row is raised, and only during ACCESS.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      wl[r] = (accessing && (addr_q == AW'(r))) ? VDD : VSS;
    end
  end

  // Bitline drivers.
  // Lines carry write data differentially during a write pulse. Otherwise
  // both lines sit precharged high, which leaves the cells unchanged.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      if (accessing && we_q) begin
        bl[c]  = wdata_q[c] ? VDD : VSS;
        blb[c] = wdata_q[c] ? VSS : VDD;
      end else begin
        bl[c]  = VDD;
        blb[c] = VDD;
      end
    end
  end

  // Sense amplifier: threshold the addressed row's cell voltages into bits.
  always_comb begin
    sensed = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (addr_q == AW'(r)) begin
        for (int c = 0; c < COLS; c++) begin
          sensed[c] = (cellV[r][c] >= VTH);
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sram_cell u_cell (
        .clk_i (clk),
        .wl_i  (wl[r]),
        .bl_i  (bl[c]),
        .blb_i (blb[c]),
        .q_o   (cellV[r][c])
      );
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank.
// Instance 0 uses the default parameters. Instance 1 uses ROWS=12,
// PRE_CYCLES=3 and WL_CYCLES=4.
module tb_sram_bank;
   import sram_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic reqS [2];
   logic weS [2];
   logic ackS [2];
   logic errS [2];
   logic busyS [2];
   logic [3:0] addrS [2];
   logic [7:0] wdataS [2];
   logic [7:0] rdataS [2];
   real vddS [2];
   real wlA [16];
   real wlB [12];

   int vectors = 0;
   int miscompares = 0;

   // Reference model: expected word contents, plus whether each word is known.
   logic [7:0] mem [2][16];
   bit known [2][16];
   int rowsOf [2] = '{16, 12};
   int preOf [2] = '{1, 3};
   int wlcOf [2] = '{2, 4};

   always #5 clk = ~clk;

   sram_bank dut0 (
      .clk(clk), .rst(rst), .req(reqS[0]), .we(weS[0]), .addr(addrS[0]),
      .wdata(wdataS[0]), .vdd(vddS[0]), .ack(ackS[0]), .err(errS[0]),
      .busy(busyS[0]), .rdata(rdataS[0]), .wl(wlA)
   );

   sram_bank #(.ROWS(12), .COLS(8), .PRE_CYCLES(3), .WL_CYCLES(4)) dut1 (
      .clk(clk), .rst(rst), .req(reqS[1]), .we(weS[1]), .addr(addrS[1]),
      .wdata(wdataS[1]), .vdd(vddS[1]), .ack(ackS[1]), .err(errS[1]),
      .busy(busyS[1]), .rdata(rdataS[1]), .wl(wlB)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Count wordlines at or above threshold and wordlines not exactly at VSS.
   function automatic void scanWl(input int s, output int hotCnt, output int hotIdx, output int nzCnt);
      hotCnt = 0;
      hotIdx = -1;
      nzCnt = 0;
      for (int r = 0; r < rowsOf[s]; r++) begin
         real v;
         v = (s == 0) ? wlA[r] : wlB[r];
         if (v >= VTH) begin
            hotCnt++;
            hotIdx = r;
         end
         if (v != VSS) nzCnt++;
      end
   endfunction

   // Issue one request on instance s and follow it to completion.
   // Checks latency, err, wordline activity, busy and rdata against the model.
   // While the access runs, the inputs are scrambled to show they are not
   // used after acceptance. With hold set, req also stays high through DONE.
   task automatic applyStimulus(input int s, input bit w, input int a, input logic [7:0] d,
                                input real v, input bit hold);
      int lat, hot, acks, wlBad, busyBad, cnt, idx, nz, expLat;
      bit expErr, er;
      logic [7:0] rd;
      expErr = (a >= rowsOf[s]) || (v < VMIN);
      expLat = expErr ? 1 : preOf[s] + wlcOf[s] + (w ? 1 : 2);
      reqS[s] = 1'b1;
      weS[s] = w;
      addrS[s] = 4'(a);
      wdataS[s] = d;
      vddS[s] = v;
      lat = 0; hot = 0; acks = 0; wlBad = 0; busyBad = 0; er = 1'b0; rd = '0;
      for (int n = 1; n <= 40 && acks == 0; n++) begin
         @(posedge clk);
         #1;
         if (!hold) reqS[s] = 1'b0;
         weS[s] = 1'($urandom);
         addrS[s] = 4'($urandom);
         wdataS[s] = 8'($urandom);
         vddS[s] = ($urandom_range(1) == 1) ? 1.0 : 1.5;
         scanWl(s, cnt, idx, nz);
         if (cnt > 1 || (cnt == 1 && idx != a)) wlBad++;
         if (cnt == 1) hot++;
         if (!busyS[s]) busyBad++;
         if (ackS[s]) begin
            acks = 1;
            lat = n;
            er = errS[s];
            rd = rdataS[s];
         end
      end
      checkOutput("ack latency", 64'(lat), 64'(expLat));
      checkOutput("err flag", 64'(er), 64'(expErr));
      checkOutput("wl active cycles", 64'(hot), 64'(expErr ? 0 : wlcOf[s]));
      checkOutput("wl wrong row", 64'(wlBad), 64'd0);
      checkOutput("busy during op", 64'(busyBad), 64'd0);
      if (!w && !expErr && known[s][a]) checkOutput("rdata", 64'(rd), 64'(mem[s][a]));
      if (!expErr && w) begin
         mem[s][a] = d;
         known[s][a] = 1'b1;
      end
      @(posedge clk);
      #1;
      reqS[s] = 1'b0;
      checkOutput("ack after done", 64'(ackS[s]), 64'd0);
      checkOutput("busy after done", 64'(busyS[s]), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("no extra accept", 64'(busyS[s]), 64'd0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt, idx, nz, s, a;
      real vsel [5] = '{1.5, 1.3, 1.2, 1.19, 1.0};
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         reqS[i] = 1'b0;
         weS[i] = 1'b0;
         addrS[i] = '0;
         wdataS[i] = '0;
         vddS[i] = 1.5;
         for (int j = 0; j < 16; j++) known[i][j] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      // Reset state.
      for (int i = 0; i < 2; i++) begin
         scanWl(i, cnt, idx, nz);
         checkOutput("reset ack", 64'(ackS[i]), 64'd0);
         checkOutput("reset err", 64'(errS[i]), 64'd0);
         checkOutput("reset busy", 64'(busyS[i]), 64'd0);
         checkOutput("reset rdata", 64'(rdataS[i]), 64'd0);
         checkOutput("reset wl", 64'(nz), 64'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Write then read back at address 3.
      $display("[TB] write/read addr 3");
      applyStimulus(0, 1'b1, 3, 8'hA5, 1.5, 1'b0);
      applyStimulus(0, 1'b0, 3, 8'h00, 1.5, 1'b0);

      // All-ones and all-zero words at the address extremes; neighbour untouched.
      $display("[TB] extremes");
      applyStimulus(0, 1'b1, 1, 8'h5A, 1.5, 1'b0);
      applyStimulus(0, 1'b1, 0, 8'hFF, 1.5, 1'b0);
      applyStimulus(0, 1'b1, 15, 8'h00, 1.5, 1'b0);
      applyStimulus(0, 1'b0, 0, 8'h00, 1.5, 1'b0);
      applyStimulus(0, 1'b0, 15, 8'h00, 1.5, 1'b0);
      applyStimulus(0, 1'b0, 1, 8'h00, 1.5, 1'b0);

      // Low supply: immediate error, no wordline activity, storage unchanged.
      $display("[TB] low vdd");
      applyStimulus(0, 1'b0, 3, 8'h00, 1.0, 1'b0);
      applyStimulus(0, 1'b1, 3, 8'h11, 1.19, 1'b0);
      applyStimulus(0, 1'b0, 3, 8'h00, 1.5, 1'b0);

      // Instance 1: address past ROWS, held req, and longer phase lengths.
      $display("[TB] 12-row bank, long phases");
      applyStimulus(1, 1'b0, 13, 8'h00, 1.5, 1'b0);
      applyStimulus(1, 1'b1, 7, 8'h81, 1.5, 1'b1);
      applyStimulus(1, 1'b0, 7, 8'h00, 1.5, 1'b1);

      // Abort a write during ACCESS with reset.
      $display("[TB] reset abort");
      applyStimulus(0, 1'b1, 6, 8'h66, 1.5, 1'b0);
      applyStimulus(0, 1'b0, 6, 8'h00, 1.5, 1'b0);
      reqS[0] = 1'b1;
      weS[0] = 1'b1;
      addrS[0] = 4'd5;
      wdataS[0] = 8'h3C;
      vddS[0] = 1.5;
      @(posedge clk);
      #1;
      reqS[0] = 1'b0;
      @(posedge clk);
      #1;
      scanWl(0, cnt, idx, nz);
      checkOutput("abort wl in access", 64'(idx), 64'd5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      scanWl(0, cnt, idx, nz);
      checkOutput("abort busy", 64'(busyS[0]), 64'd0);
      checkOutput("abort ack", 64'(ackS[0]), 64'd0);
      checkOutput("abort wl", 64'(nz), 64'd0);
      checkOutput("abort rdata", 64'(rdataS[0]), 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         checkOutput("abort no late ack", 64'(ackS[0]), 64'd0);
      end
      known[0][5] = 1'b0;
      applyStimulus(0, 1'b0, 6, 8'h00, 1.5, 1'b0);

      // Random traffic on both instances.
      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         s = i % 2;
         a = $urandom_range(15);
         applyStimulus(s, 1'($urandom), a, 8'($urandom), vsel[$urandom_range(4)], 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 Parameters: ROWS, default 16, number of words; COLS, default 8, bits per word; PRE_CYCLES, default 1, bitline precharge cycles (>=1); WL_CYCLES, default 2, wordline pulse cycles (>=1).
REQ-002 Ports, one per line, clock and reset first:
  clk  in  1  single clock; all state updates on its rising edge
  rst  in  1  reset, synchronous, active-high
  req  in  1  access request, sampled in IDLE only
  we  in  1  1 = write, 0 = read; sampled with req
  addr  in  $clog2(ROWS)  word address; sampled with req
  wdata  in  COLS  write data; sampled with req
  vdd  in  real  supply voltage; sampled with req
  ack  out  1  one-cycle completion pulse
  err  out  1  one-cycle error pulse, only coincident with ack
  busy  out  1  high from the cycle after acceptance through the DONE cycle
  rdata  out  COLS  read data; valid while ack=1 on a read, otherwise held
  wl  out  real [ROWS]  per-row wordline voltage
REQ-003 Clock is clk; reset is rst, synchronous and active-high; the block uses no other clock or reset.

Function
REQ-004 The FSM SHALL have states IDLE, PRECHARGE, ACCESS, SENSE, DONE.
REQ-005 IDLE with req=1 SHALL accept the request on that edge: latch we, addr, wdata; check the error conditions; go to PRECHARGE, or to DONE with err flagged.
REQ-006 Error conditions at acceptance: addr >= ROWS, or vdd < VMIN (1.2). On error the block SHALL do no wordline activity and no storage change.
REQ-007 PRECHARGE SHALL last exactly PRE_CYCLES cycles, with all wl = VSS.
REQ-008 ACCESS SHALL last exactly WL_CYCLES cycles, with wl[addr] = VDD (1.5) and all other wl = VSS; on a write, the stored word at addr SHALL equal wdata by the end of ACCESS.
REQ-009 After ACCESS, a read SHALL go to SENSE for 1 cycle, capturing the stored word into rdata with bits thresholded at VTH (0.8); a write SHALL go directly to DONE.
REQ-010 DONE SHALL last 1 cycle with ack=1 (err=1 if flagged), then return to IDLE.
REQ-011 Latency, as edges from the accepting edge to the first ack-high cycle:
  write: PRE_CYCLES+WL_CYCLES+1 (default 4)
  read: PRE_CYCLES+WL_CYCLES+2 (default 5)
  error: 1
REQ-012 req outside IDLE (including the DONE cycle) SHALL be ignored; the earliest back-to-back acceptance is the first IDLE cycle after DONE.
REQ-013 Changes to vdd, addr, we or wdata after acceptance SHALL NOT affect the access in flight.
REQ-014 At most one wl element SHALL be >= VTH in any cycle; none outside ACCESS.
REQ-015 A write SHALL modify only the addressed word.
REQ-016 Reading a never-written word SHALL return the cell's undefined stored value; the bench treats it as don't-care.

Reset
REQ-017 While rst=1 the block SHALL enter IDLE with ack=0, err=0, busy=0, rdata=0 and all wl = VSS.
REQ-018 rst asserted mid-operation SHALL abort the access without ack.
REQ-019 An aborted write SHALL leave the addressed word either old or new data; all other words are unchanged.
REQ-020 Reset SHALL NOT clear stored words.

Structure
REQ-021 Package sram_pkg SHALL hold VDD=1.5, VSS=0.0, VTH=0.8, VMIN=1.2 and the FSM state enum.
REQ-022 Storage SHALL be a ROWS x COLS array of the existing sram_cell sub-module, driven by real wordlines and bitlines; the FSM and sequencing SHALL live in sram_bank.

Verification
REQ-023 Write 0xA5 to addr 3, then read addr 3 (defaults, vdd=1.5) -> write ack at edge 4, read ack at edge 5, rdata=0xA5, err=0.
REQ-024 Write 0xFF to addr 0 and 0x00 to addr 15, then read both -> 0xFF and 0x00; addr 1 still holds its prior value.
REQ-025 Read request with vdd=1.0 -> ack and err together at edge 1, wl never >= VTH, storage unchanged.
REQ-026 ROWS=12, request addr=13 -> err at edge 1; req held high during busy -> exactly one ack per accepted request.
REQ-027 rst asserted during ACCESS of a write of 0x3C to addr 5 -> next cycle IDLE, wl all 0.0, no ack; a later read of addr 6 returns its prior value.
REQ-028 PRE_CYCLES=3, WL_CYCLES=4 read -> wl[addr]=1.5 for exactly 4 cycles, ack at edge 9.
